uart_rx_frame_parser: RTL and testbench
=======================================

Name: uart_rx_frame_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (data byte, data-valid pulse, parity/stop error flags).
- Assembles multi-byte command frames and issues single-cycle register-file write/read strobes and ALU-execute strobes to the system control path.
- Handles frame abort on receive errors and, optionally, on inter-byte timeout.

Parameters:
- DATA_WIDTH, 8, width of a received byte and of register write data
- ADDR_WIDTH, 4, register-file address width; taken from the address byte LSBs
- FUN_WIDTH, 4, ALU function code width; taken from the function byte LSBs
- TIMEOUT_CYCLES, 4096, idle CLK cycles between bytes before a partial frame is aborted (used only with the optional feature)

Ports:
- CLK  in  1  block clock (same domain as the UART receiver output)
- RST  in  1  asynchronous active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte; valid only while RX_D_VLD=1
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RX_PAR_ERR  in  1  parity error pulse for the current byte
- RX_STP_ERR  in  1  stop error pulse for the current byte
- RF_WrEn  out  1  register write strobe, one cycle
- RF_RdEn  out  1  register read strobe, one cycle
- RF_Address  out  ADDR_WIDTH  register address, valid with RF_WrEn or RF_RdEn
- RF_WrData  out  DATA_WIDTH  register write data, valid with RF_WrEn
- ALU_EN  out  1  ALU execute strobe, one cycle
- ALU_FUN  out  FUN_WIDTH  ALU function, valid with ALU_EN
- Frame_Busy  out  1  high while a frame is partially received
- Frame_Err  out  1  one-cycle pulse on any frame abort or unknown command

Behaviour:
- Reset: every output is 0; state is IDLE; the timeout counter is 0. Reset is asynchronous and may occur mid-frame; any partial frame is discarded with no strobe and no Frame_Err.
- Outputs are registered. A strobe asserts on the CLK edge after the RX_D_VLD cycle that completes its field, giving latency 1. Address, data and function outputs hold their last value between strobes.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN.
- Command byte accepted in IDLE:
  - 0xAA: go to WR_ADDR.
  - 0xBB: go to RD_ADDR.
  - 0xCC: go to OPA.
  - 0xDD: go to FUN.
  - Any other value: pulse Frame_Err and stay in IDLE.
- WR_ADDR: latch byte[ADDR_WIDTH-1:0] into RF_Address; go to WR_DATA. Upper address bits are ignored.
- WR_DATA: drive RF_WrData = byte and pulse RF_WrEn; go to IDLE.
- RD_ADDR: drive RF_Address = byte LSBs and pulse RF_RdEn; go to IDLE.
- OPA: drive RF_Address = 0 and RF_WrData = byte, pulse RF_WrEn; go to OPB.
- OPB: drive RF_Address = 1 and RF_WrData = byte, pulse RF_WrEn; go to FUN.
- FUN: drive ALU_FUN = byte[FUN_WIDTH-1:0] and pulse ALU_EN; go to IDLE.
- Frame_Busy = 1 in every state except IDLE.
- Errors: RX_PAR_ERR or RX_STP_ERR high in any cycle (with or without RX_D_VLD) aborts the frame.
  - Outside IDLE: pulse Frame_Err, go to IDLE, issue no strobe for that byte.
  - In IDLE: pulse Frame_Err and discard the byte.
  - An error has priority over RX_D_VLD when both occur in the same cycle.
- Operand writes already issued in OPA/OPB are not rolled back when the frame later aborts.
- At most one strobe among RF_WrEn, RF_RdEn and ALU_EN is high in any cycle.
- RX_D_VLD is assumed never to assert on consecutive cycles; the design still accepts back-to-back bytes, one per cycle.

Optional Feature:
- Macro: UART_FRAME_TIMEOUT_EN.
- Defined: a counter clears on every RX_D_VLD and increments each CLK cycle while not in IDLE. When it reaches TIMEOUT_CYCLES-1 with no byte arriving, pulse Frame_Err, return to IDLE and clear the counter. The counter is held at 0 in IDLE and saturates, so it never wraps.
- Not defined: no counter exists; a partial frame waits indefinitely for its next byte.

Test Plan:
- Bytes 0xAA, 0x05, 0x3C -> one RF_WrEn pulse with RF_Address=5 and RF_WrData=0x3C, one cycle after the third RX_D_VLD. Frame_Busy is high from the first byte until the strobe.
- Bytes 0xBB, 0xF7 -> one RF_RdEn pulse with RF_Address=7 (upper bits ignored); no other strobe.
- Bytes 0xCC, 0x12, 0x34, 0x02 -> RF_WrEn pulses at address 0 with 0x12 and at address 1 with 0x34, then ALU_EN pulses with ALU_FUN=2; three strobes total.
- Byte 0x55 in IDLE -> Frame_Err pulses once and the FSM stays in IDLE. Then bytes 0xAA, 0x03 followed by RX_PAR_ERR together with RX_D_VLD on 0x99 -> Frame_Err pulses, there is no RF_WrEn, and the FSM returns to IDLE.
- RST driven low after 0xCC, 0x12 -> all outputs go to 0 immediately. After RST releases, 0xDD, 0x01 produces ALU_EN with ALU_FUN=1.
- With UART_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte 0xAA, then no byte for 16 cycles -> Frame_Err pulses, Frame_Busy drops, and a following 0x05 is treated as a new (unknown) command, causing another Frame_Err.

Source files
------------

// File: rtl/uart_rx_frame_parser.sv
// UART receive frame parser: turns received bytes into register-file and ALU strobes.
// Optional inter-byte timeout abort is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_parser #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_STP_ERR,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  Frame_Busy,
    output logic                  Frame_Err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        OPA,
        OPB,
        FUN
    } state_t;

    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

    state_t                state, state_nx;
    logic                  wr_en_nx, rd_en_nx, alu_en_nx, err_nx;
    logic [ADDR_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0] data_nx;
    logic [FUN_WIDTH-1:0]  fun_nx;
    logic                  rx_err;
    logic                  timeout;

    assign rx_err = RX_PAR_ERR | RX_STP_ERR;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] to_cnt;

    assign timeout = (state != IDLE) && !RX_D_VLD && (to_cnt == TO_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            to_cnt <= '0;
        end else if (RX_D_VLD || state_nx == IDLE) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LAST) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    // Without the counter a partial frame waits forever.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        wr_en_nx  = 1'b0;
        rd_en_nx  = 1'b0;
        alu_en_nx = 1'b0;
        err_nx    = 1'b0;
        addr_nx   = RF_Address;
        data_nx   = RF_WrData;
        fun_nx    = ALU_FUN;
        if (rx_err || timeout) begin
            err_nx   = 1'b1;
            state_nx = IDLE;
        end else if (RX_D_VLD) begin
            unique case (state)
                IDLE: begin
                    if (RX_P_DATA == CMD_WR) begin
                        state_nx = WR_ADDR;
                    end else if (RX_P_DATA == CMD_RD) begin
                        state_nx = RD_ADDR;
                    end else if (RX_P_DATA == CMD_ALU) begin
                        state_nx = OPA;
                    end else if (RX_P_DATA == CMD_FUN) begin
                        state_nx = FUN;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                WR_ADDR: begin
                    addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_nx = WR_DATA;
                end
                WR_DATA: begin
                    data_nx  = RX_P_DATA;
                    wr_en_nx = 1'b1;
                    state_nx = IDLE;
                end
                RD_ADDR: begin
                    addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_nx = 1'b1;
                    state_nx = IDLE;
                end
                OPA: begin
                    addr_nx  = '0;
                    data_nx  = RX_P_DATA;
                    wr_en_nx = 1'b1;
                    state_nx = OPB;
                end
                OPB: begin
                    addr_nx  = ADDR_WIDTH'(1);
                    data_nx  = RX_P_DATA;
                    wr_en_nx = 1'b1;
                    state_nx = FUN;
                end
                FUN: begin
                    fun_nx    = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_nx = 1'b1;
                    state_nx  = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            ALU_EN     <= 1'b0;
            Frame_Err  <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            ALU_FUN    <= '0;
        end else begin
            RF_WrEn    <= wr_en_nx;
            RF_RdEn    <= rd_en_nx;
            ALU_EN     <= alu_en_nx;
            Frame_Err  <= err_nx;
            RF_Address <= addr_nx;
            RF_WrData  <= data_nx;
            ALU_FUN    <= fun_nx;
        end
    end

    assign Frame_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser; timeout checks run when
// UART_FRAME_TIMEOUT_EN is defined.
module tb_uart_rx_frame_parser;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic       RX_PAR_ERR = 1'b0;
    logic       RX_STP_ERR = 1'b0;
    logic       RF_WrEn, RF_RdEn, ALU_EN, Frame_Busy, Frame_Err;
    logic [3:0] RF_Address;
    logic [7:0] RF_WrData;
    logic [3:0] ALU_FUN;

    int n_assert = 0;
    int n_fail   = 0;

    uart_rx_frame_parser #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .FUN_WIDTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .RX_P_DATA(RX_P_DATA),
        .RX_D_VLD(RX_D_VLD),
        .RX_PAR_ERR(RX_PAR_ERR),
        .RX_STP_ERR(RX_STP_ERR),
        .RF_WrEn(RF_WrEn),
        .RF_RdEn(RF_RdEn),
        .RF_Address(RF_Address),
        .RF_WrData(RF_WrData),
        .ALU_EN(ALU_EN),
        .ALU_FUN(ALU_FUN),
        .Frame_Busy(Frame_Busy),
        .Frame_Err(Frame_Err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobes(input string tag, input logic wr,
                           input logic rd, input logic alu,
                           input logic err, input logic busy);
        chk({tag, ".wr"}, 32'(RF_WrEn), 32'(wr));
        chk({tag, ".rd"}, 32'(RF_RdEn), 32'(rd));
        chk({tag, ".alu"}, 32'(ALU_EN), 32'(alu));
        chk({tag, ".err"}, 32'(Frame_Err), 32'(err));
        chk({tag, ".busy"}, 32'(Frame_Busy), 32'(busy));
    endtask

    // Drives one byte for one cycle; returns at the next falling edge,
    // after the capturing rising edge.
    task automatic send(input logic [7:0] b, input logic perr,
                        input logic serr);
        RX_P_DATA  = b;
        RX_D_VLD   = 1'b1;
        RX_PAR_ERR = perr;
        RX_STP_ERR = serr;
        @(negedge CLK);
        RX_D_VLD   = 1'b0;
        RX_PAR_ERR = 1'b0;
        RX_STP_ERR = 1'b0;
    endtask

    initial begin
        #1;
        strobes("rst", 0, 0, 0, 0, 0);
        chk("rst.addr", 32'(RF_Address), 0);
        chk("rst.data", 32'(RF_WrData), 0);
        chk("rst.fun", 32'(ALU_FUN), 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // register write
        send(8'hAA, 0, 0);
        strobes("wr1", 0, 0, 0, 0, 1);
        send(8'h05, 0, 0);
        strobes("wr2", 0, 0, 0, 0, 1);
        send(8'h3C, 0, 0);
        strobes("wr3", 1, 0, 0, 0, 0);
        chk("wr3.addr", 32'(RF_Address), 32'h5);
        chk("wr3.data", 32'(RF_WrData), 32'h3C);
        @(negedge CLK);
        strobes("wr.after", 0, 0, 0, 0, 0);
        chk("wr.hold", 32'(RF_WrData), 32'h3C);

        // register read, upper address bits dropped
        send(8'hBB, 0, 0);
        strobes("rd1", 0, 0, 0, 0, 1);
        send(8'hF7, 0, 0);
        strobes("rd2", 0, 1, 0, 0, 0);
        chk("rd2.addr", 32'(RF_Address), 32'h7);
        @(negedge CLK);

        // ALU operation
        send(8'hCC, 0, 0);
        strobes("alu1", 0, 0, 0, 0, 1);
        send(8'h12, 0, 0);
        strobes("alu2", 1, 0, 0, 0, 1);
        chk("alu2.addr", 32'(RF_Address), 32'h0);
        chk("alu2.data", 32'(RF_WrData), 32'h12);
        send(8'h34, 0, 0);
        strobes("alu3", 1, 0, 0, 0, 1);
        chk("alu3.addr", 32'(RF_Address), 32'h1);
        chk("alu3.data", 32'(RF_WrData), 32'h34);
        send(8'h02, 0, 0);
        strobes("alu4", 0, 0, 1, 0, 0);
        chk("alu4.fun", 32'(ALU_FUN), 32'h2);
        @(negedge CLK);

        // unknown command, then parity abort on the data byte
        send(8'h55, 0, 0);
        strobes("unk", 0, 0, 0, 1, 0);
        send(8'hAA, 0, 0);
        send(8'h03, 0, 0);
        strobes("perr.pre", 0, 0, 0, 0, 1);
        chk("perr.addr", 32'(RF_Address), 32'h3);
        send(8'h99, 1, 0);
        strobes("perr", 0, 0, 0, 1, 0);
        @(negedge CLK);
        strobes("perr.after", 0, 0, 0, 0, 0);

        // stop error without a byte, in IDLE and mid-frame
        RX_STP_ERR = 1'b1;
        @(negedge CLK);
        RX_STP_ERR = 1'b0;
        strobes("serr.idle", 0, 0, 0, 1, 0);
        send(8'hBB, 0, 0);
        RX_STP_ERR = 1'b1;
        @(negedge CLK);
        RX_STP_ERR = 1'b0;
        strobes("serr.mid", 0, 0, 0, 1, 0);

        // back-to-back bytes on consecutive cycles
        RX_D_VLD  = 1'b1;
        RX_P_DATA = 8'hAA;
        @(negedge CLK);
        RX_P_DATA = 8'h0A;
        @(negedge CLK);
        RX_P_DATA = 8'h5B;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        strobes("b2b", 1, 0, 0, 0, 0);
        chk("b2b.addr", 32'(RF_Address), 32'hA);
        chk("b2b.data", 32'(RF_WrData), 32'h5B);

        // asynchronous reset mid-frame
        send(8'hCC, 0, 0);
        send(8'h12, 0, 0);
        strobes("arst.pre", 1, 0, 0, 0, 1);
        #2 RST = 1'b0;
        #1;
        strobes("arst", 0, 0, 0, 0, 0);
        chk("arst.addr", 32'(RF_Address), 0);
        chk("arst.data", 32'(RF_WrData), 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send(8'hDD, 0, 0);
        strobes("fun1", 0, 0, 0, 0, 1);
        send(8'h01, 0, 0);
        strobes("fun2", 0, 0, 1, 0, 0);
        chk("fun2.fun", 32'(ALU_FUN), 32'h1);
        @(negedge CLK);

`ifdef UART_FRAME_TIMEOUT_EN
        begin
            int seen;
            seen = 0;
            send(8'hAA, 0, 0);
            for (int i = 1; i <= 24 && seen == 0; i++) begin
                @(negedge CLK);
                if (Frame_Err) seen = i;
            end
            chk("to.cycles", 32'(seen), 32'd16);
            chk("to.busy", 32'(Frame_Busy), 0);
            send(8'h05, 0, 0);
            strobes("to.unk", 0, 0, 0, 1, 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
